// File: rtl/pcie_us_pkg.sv
// Shared definitions for the UltraScale PCIe CC/RQ-side stream arbiters.
package pcie_us_pkg;

  localparam int CC_TUSER_WIDTH = 33;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Index width that never collapses to zero for single- or dual-source builds.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);

  // Walk the offsets 1..N from 'last'; offset N wraps back to 'last' itself.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (i == ((int'(last) + k) % N))) begin
          pick = IW'(i);
          any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/s_axis_cc_arbiter.sv
// Packet-atomic round-robin merge of NUM_REQ CC streams onto the PCIe s_axis_cc port.
// Define S_AXIS_CC_ARB_OUTREG_EN to insert a 2-entry skid register on the outputs.
module s_axis_cc_arbiter
  import pcie_us_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int USER_WIDTH = CC_TUSER_WIDTH,
  localparam int GW        = clog2_safe(NUM_REQ)
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]  s_tkeep,
  input  logic [NUM_REQ-1:0]             s_tlast,
  input  logic [NUM_REQ*USER_WIDTH-1:0]  s_tuser,
  input  logic [NUM_REQ-1:0]             s_tvalid,
  output logic [NUM_REQ-1:0]             s_tready,
  input  logic [NUM_REQ-1:0]             cfg_req_mask,
  output logic [DATA_WIDTH-1:0]          s_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_cc_tkeep,
  output logic                           s_axis_cc_tlast,
  output logic [USER_WIDTH-1:0]          s_axis_cc_tuser,
  output logic                           s_axis_cc_tvalid,
  input  logic [3:0]                     s_axis_cc_tready,
  output logic [GW-1:0]                  grant_idx,
  output logic                           busy
);

  arb_state_t state;

  logic [DATA_WIDTH-1:0] src_data [NUM_REQ];
  logic [KEEP_WIDTH-1:0] src_keep [NUM_REQ];
  logic [USER_WIDTH-1:0] src_user [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign src_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign src_keep[i] = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign src_user[i] = s_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  logic          locked;
  logic          sel_valid;
  logic          sel_last;
  logic          accept_rdy;
  logic          beat;
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          unused_tready;

  assign locked        = (state == ARB_LOCKED);
  assign sel_valid     = s_tvalid[grant_idx];
  assign sel_last      = s_tlast[grant_idx];
  assign beat          = locked & sel_valid & accept_rdy;
  assign unused_tready = ^s_axis_cc_tready[3:1];

  rr_pick #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_pick (
    .req  (s_tvalid & ~cfg_req_mask),
    .last (grant_idx),
    .pick (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    s_tready = '0;
    if (locked) s_tready[grant_idx] = accept_rdy;
  end

  // Grant is held from arbitration until the tlast beat is accepted downstream.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state     <= ARB_IDLE;
      grant_idx <= GW'(NUM_REQ - 1);
      busy      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_idx <= pick_idx;
            state     <= ARB_LOCKED;
            busy      <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (beat && sel_last) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef S_AXIS_CC_ARB_OUTREG_EN
  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  logic [PW-1:0] skid_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    skid_cnt;
  logic          skid_pop;
  logic          skid_vld;
  logic [PW-1:0] head;

  // Ready toward the sources depends only on occupancy, never on the IP's tready.
  assign accept_rdy = (skid_cnt != 2'd2);
  assign skid_vld   = (skid_cnt != 2'd0);
  assign skid_pop   = skid_vld & s_axis_cc_tready[0];
  assign head       = skid_vld ? skid_mem[rd_ptr] : '0;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      if (beat) begin
        skid_mem[wr_ptr] <= {src_data[grant_idx], src_keep[grant_idx], sel_last,
                             src_user[grant_idx]};
        wr_ptr           <= ~wr_ptr;
      end
      if (skid_pop) rd_ptr <= ~rd_ptr;
      case ({beat, skid_pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  assign s_axis_cc_tvalid = skid_vld;
  assign {s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tuser} = head;
`else
  assign accept_rdy       = s_axis_cc_tready[0];
  assign s_axis_cc_tvalid = locked & sel_valid;
  assign s_axis_cc_tdata  = locked ? src_data[grant_idx] : '0;
  assign s_axis_cc_tkeep  = locked ? src_keep[grant_idx] : '0;
  assign s_axis_cc_tlast  = locked & sel_last;
  assign s_axis_cc_tuser  = locked ? src_user[grant_idx] : '0;
`endif

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
// Scoreboard bench for s_axis_cc_arbiter: source drivers, output monitor, directed packets.
module tb_s_axis_cc_arbiter;

  localparam int NR = 2;
  localparam int DW = 128;
  localparam int KW = 4;
  localparam int UW = 33;

  logic             user_clk = 1'b0;
  logic             user_reset = 1'b1;
  logic [NR*DW-1:0] s_tdata;
  logic [NR*KW-1:0] s_tkeep;
  logic [NR-1:0]    s_tlast;
  logic [NR*UW-1:0] s_tuser;
  logic [NR-1:0]    s_tvalid;
  logic [NR-1:0]    s_tready;
  logic [NR-1:0]    cfg_req_mask = '0;
  logic [DW-1:0]    s_axis_cc_tdata;
  logic [KW-1:0]    s_axis_cc_tkeep;
  logic             s_axis_cc_tlast;
  logic [UW-1:0]    s_axis_cc_tuser;
  logic             s_axis_cc_tvalid;
  logic [3:0]       s_axis_cc_tready;
  logic [0:0]       grant_idx;
  logic             busy;

  s_axis_cc_arbiter dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .s_tdata          (s_tdata),
    .s_tkeep          (s_tkeep),
    .s_tlast          (s_tlast),
    .s_tuser          (s_tuser),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .cfg_req_mask     (cfg_req_mask),
    .s_axis_cc_tdata  (s_axis_cc_tdata),
    .s_axis_cc_tkeep  (s_axis_cc_tkeep),
    .s_axis_cc_tlast  (s_axis_cc_tlast),
    .s_axis_cc_tuser  (s_axis_cc_tuser),
    .s_axis_cc_tvalid (s_axis_cc_tvalid),
    .s_axis_cc_tready (s_axis_cc_tready),
    .grant_idx        (grant_idx),
    .busy             (busy)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_q[$];
  int    fire_cyc[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    low_left = 0;
  logic  fire0 = 1'b0;
  logic  fire1 = 1'b0;
  logic  tready_bit = 1'b1;

  always @(posedge user_clk) cyc <= cyc + 1;

  function automatic beat_t makeBeat(int src, int pkt, int b, int n);
    beat_t r;
    r.data = {32'hA000_0000 + 32'(src * 256 + pkt * 16 + b), 32'h1357_9BDF ^ 32'(pkt),
              32'hCAFE_0000 + 32'(b), 32'h0BAD_F00D ^ 32'(src)};
    r.last = (b == n - 1);
    r.keep = r.last ? 4'h3 : 4'hF;
    r.user = 33'(src * 1000 + pkt * 10 + b) | (src == 1 ? 33'h1_0000_0000 : 33'h0);
    return r;
  endfunction

  task automatic applyStimulus(int src, int pkt, int n);
    for (int b = 0; b < n; b++) begin
      if (src == 0) q0.push_back(makeBeat(src, pkt, b, n));
      else          q1.push_back(makeBeat(src, pkt, b, n));
    end
  endtask

  task automatic expectPacket(int src, int pkt, int n);
    for (int b = 0; b < n; b++) exp_q.push_back(makeBeat(src, pkt, b, n));
  endtask

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(beat_t act);
    beat_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_beat: got data %0h, want none", act.data);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("[TB] FAIL out_beat: got %0h/%0h/%0b/%0h, want %0h/%0h/%0b/%0h",
                 act.data, act.keep, act.last, act.user, e.data, e.keep, e.last, e.user);
      end
    end
  endtask

  task automatic nextSample();
    @(negedge user_clk);
    #4;
  endtask

  task automatic waitDrain(string name, int budget);
    int n;
    n = 0;
    while (n < budget && (exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0)) begin
      nextSample();
      n++;
    end
    check(name, 128'(exp_q.size() + q0.size() + q1.size()), 128'd0);
    nextSample();
    nextSample();
  endtask

  task automatic waitBusy(string name, int budget);
    int n;
    n = 0;
    while (n < budget && !busy) begin
      nextSample();
      n++;
    end
    check(name, 128'(busy), 128'd1);
  endtask

  // Source drivers: present queue heads at negedge, sample handshakes just before posedge.
  initial begin
    beat_t b;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    s_axis_cc_tready = 4'hF;
    forever begin
      @(negedge user_clk);
      if (fire0 && q0.size() > 0) void'(q0.pop_front());
      if (fire1 && q1.size() > 0) void'(q1.pop_front());
      case (ready_mode)
        1: tready_bit = ~tready_bit;
        2: if (low_left > 0) begin tready_bit = 1'b0; low_left--; end else tready_bit = 1'b1;
        default: tready_bit = 1'b1;
      endcase
      s_axis_cc_tready = {3'b111, tready_bit};
      if (q0.size() > 0) begin
        b = q0[0];
        s_tvalid[0] = 1'b1; s_tdata[0 +: DW] = b.data; s_tkeep[0 +: KW] = b.keep;
        s_tlast[0] = b.last; s_tuser[0 +: UW] = b.user;
      end else s_tvalid[0] = 1'b0;
      if (q1.size() > 0) begin
        b = q1[0];
        s_tvalid[1] = 1'b1; s_tdata[DW +: DW] = b.data; s_tkeep[KW +: KW] = b.keep;
        s_tlast[1] = b.last; s_tuser[UW +: UW] = b.user;
      end else s_tvalid[1] = 1'b0;
      #4;
      fire0 = s_tvalid[0] & s_tready[0];
      fire1 = s_tvalid[1] & s_tready[1];
    end
  end

  // Output monitor: scoreboard pop on every accepted beat plus per-cycle ready/valid rules.
  initial begin
    logic [1:0] allowed;
    forever begin
      nextSample();
      if (!user_reset) begin
        if (s_axis_cc_tvalid && s_axis_cc_tready[0]) begin
          fire_cyc.push_back(cyc);
          checkOutput({s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tuser});
        end
        allowed = busy ? (2'b01 << grant_idx) : 2'b00;
        check("stray_tready", 128'(s_tready & ~allowed), 128'd0);
`ifndef S_AXIS_CC_ARB_OUTREG_EN
        check("tready_mirror", 128'(s_tready[grant_idx]), 128'(busy & s_axis_cc_tready[0]));
        check("tvalid_pass", 128'(s_axis_cc_tvalid), 128'(busy & s_tvalid[grant_idx]));
`endif
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (3) nextSample();
    check("rst_grant", 128'(grant_idx), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_tvalid", 128'(s_axis_cc_tvalid), 128'd0);
    check("rst_tready", 128'(s_tready), 128'd0);
    check("rst_tdata", s_axis_cc_tdata, 128'd0);
    @(negedge user_clk);
    user_reset = 1'b0;
    nextSample();

    // Contention: order 0,1,0,1 with exactly one bubble between packets
    $display("[TB] contention");
    fire_cyc.delete();
    applyStimulus(0, 0, 2); applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 2); applyStimulus(1, 1, 2);
    expectPacket(0, 0, 2); expectPacket(1, 0, 2); expectPacket(0, 1, 2); expectPacket(1, 1, 2);
    waitDrain("contention_drain", 60);
    check("contention_beats", 128'(fire_cyc.size()), 128'd8);
    if (fire_cyc.size() == 8)
      for (int k = 1; k < 8; k++)
        check($sformatf("contention_gap%0d", k), 128'(fire_cyc[k] - fire_cyc[k-1]),
              (k % 2 == 1) ? 128'd1 : 128'd2);

    // Single source, 3 beats
    $display("[TB] single source");
    applyStimulus(0, 2, 3);
    expectPacket(0, 2, 3);
    n = 0;
    do begin nextSample(); n++; end while (!s_tvalid[0] && n < 5);
    check("single_busy_pre", 128'(busy), 128'd0);
    nextSample();
    check("single_busy_up", 128'(busy), 128'd1);
    check("single_grant", 128'(grant_idx), 128'd0);
    repeat (3) nextSample();
    check("single_busy_down", 128'(busy), 128'd0);
    waitDrain("single_drain", 20);

    // Backpressure: IP ready toggles during a 4-beat packet from src1
    $display("[TB] backpressure");
    ready_mode = 1;
    applyStimulus(1, 0, 4);
    expectPacket(1, 0, 4);
    waitBusy("bp_grant_busy", 10);
    check("bp_grant", 128'(grant_idx), 128'd1);
    waitDrain("bp_drain", 40);
    ready_mode = 0;

    // Mask src0 mid-packet: its packet finishes, then only src1 is granted
    $display("[TB] mask");
    applyStimulus(0, 3, 4); applyStimulus(0, 4, 2);
    applyStimulus(1, 1, 2); applyStimulus(1, 2, 2);
    expectPacket(0, 3, 4); expectPacket(1, 1, 2); expectPacket(1, 2, 2); expectPacket(0, 4, 2);
    waitBusy("mask_busy", 10);
    check("mask_first_grant", 128'(grant_idx), 128'd0);
    @(negedge user_clk);
    cfg_req_mask = 2'b01;
    n = 0;
    while (exp_q.size() > 2 && n < 60) begin nextSample(); n++; end
    repeat (4) nextSample();
    check("mask_held_busy", 128'(busy), 128'd0);
    check("mask_held_q0", 128'(q0.size()), 128'd2);
    cfg_req_mask = 2'b00;
    waitDrain("mask_drain", 40);

    // Asynchronous reset during beat 2 of 4; first grant afterwards is source 0
    $display("[TB] reset mid-packet");
    applyStimulus(0, 5, 4);
    expectPacket(0, 5, 4);
    waitBusy("rst_pkt_busy", 10);
    @(negedge user_clk);
    #2;
    user_reset = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    #1;
    check("async_tvalid", 128'(s_axis_cc_tvalid), 128'd0);
    check("async_tready", 128'(s_tready), 128'd0);
    check("async_busy", 128'(busy), 128'd0);
    check("async_grant", 128'(grant_idx), 128'd1);
    repeat (2) @(negedge user_clk);
    user_reset = 1'b0;
    nextSample();
    applyStimulus(1, 3, 1); applyStimulus(0, 6, 1);
    expectPacket(0, 6, 1); expectPacket(1, 3, 1);
    waitBusy("post_rst_busy", 10);
    check("post_rst_grant", 128'(grant_idx), 128'd0);
    waitDrain("post_rst_drain", 30);

    // IP ready held low for 10 cycles with both sources loaded
    $display("[TB] long stall");
    low_left = 10;
    ready_mode = 2;
    applyStimulus(1, 4, 3); applyStimulus(0, 7, 3);
    expectPacket(0, 7, 3); expectPacket(1, 4, 3);
    waitDrain("stall_drain", 80);
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
